// File: rtl/sort_result_capture.sv
// Capture end of the bubble-sorter stream: buffers sorted (row, data)
// pairs, checks completeness and order, and measures capture latency.
module sort_result_capture #(
  parameter int SIZE = 15,
  parameter int DW   = 8,
  parameter int RW   = 4,
  parameter int CW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [RW-1:0] in_row,
  input  logic [DW-1:0] in_data,
  input  logic          sort_done,
  input  logic [RW-1:0] rd_index,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          capture_done,
  output logic          order_error,
  output logic          missing_error,
  output logic          range_error,
  output logic [CW-1:0] cycles
);

  localparam int DEPTH = 2 ** RW;
  localparam logic [RW:0]   SIZE_W = (RW + 1)'(SIZE);
  localparam logic [RW-1:0] LAST_I = RW'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    CHECK,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [DEPTH-1:0] seen_q, seen_d;
  logic [RW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cycles_q, cycles_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            order_q, order_d;
  logic            miss_q, miss_d;
  logic            range_q, range_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;

  logic [DW-1:0]   mem_q [SIZE];
  logic            wr_en;
  logic            row_ok;
  logic            all_seen;
  logic            go_check;
  logic [RW-1:0]   idx_m1;
  logic [CW-1:0]   cycles_inc;

  assign row_ok     = ({1'b0, in_row} < SIZE_W);
  assign all_seen   = &seen_d[SIZE-1:0];
  assign idx_m1     = idx_q - RW'(1);
  assign cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    seen_d   = seen_q;
    idx_d    = idx_q;
    cycles_d = cycles_q;
    order_d  = order_q;
    miss_d   = miss_q;
    range_d  = range_q;
    wr_en    = 1'b0;
    go_check = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cycles_d = CW'(1);
          if (row_ok) begin
            wr_en          = 1'b1;
            seen_d[in_row] = 1'b1;
          end else begin
            range_d = 1'b1;
          end
          go_check = all_seen || sort_done;
          state_d  = go_check ? CHECK : CAPTURE;
        end else if (sort_done) begin
          go_check = 1'b1;
          state_d  = CHECK;
        end
      end
      CAPTURE: begin
        cycles_d = cycles_inc;
        if (in_valid) begin
          if (row_ok) begin
            wr_en          = 1'b1;
            seen_d[in_row] = 1'b1;
          end else begin
            range_d = 1'b1;
          end
        end
        if (all_seen || sort_done) begin
          go_check = 1'b1;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        // no element ever accepted: nothing to time
        if (cycles_q != '0) cycles_d = cycles_inc;
        if (seen_q[idx_m1] && seen_q[idx_q] &&
            (mem_q[idx_m1] > mem_q[idx_q]))
          order_d = 1'b1;
        if (idx_q == LAST_I) state_d = DONE;
        else idx_d = idx_q + RW'(1);
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase

    if (go_check) begin
      idx_d  = RW'(1);
      miss_d = ~all_seen;
    end

    busy_d = (state_d == CAPTURE) || (state_d == CHECK);
    done_d = (state_d == DONE);
  end

  always_comb begin
    rd_data_d = '0;
    if ({1'b0, rd_index} < SIZE_W) rd_data_d = mem_q[rd_index];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q  <= IDLE;
      seen_q   <= '0;
      idx_q    <= '0;
      cycles_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      order_q  <= 1'b0;
      miss_q   <= 1'b0;
      range_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      seen_q   <= seen_d;
      idx_q    <= idx_d;
      cycles_q <= cycles_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      order_q  <= order_d;
      miss_q   <= miss_d;
      range_q  <= range_d;
    end
  end

  // readout keeps running across clear; only rst zeroes it
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && wr_en) mem_q[in_row] <= in_data;
  end

  assign rd_data       = rd_data_q;
  assign busy          = busy_q;
  assign capture_done  = done_q;
  assign order_error   = order_q;
  assign missing_error = miss_q;
  assign range_error   = range_q;
  assign cycles        = cycles_q;

endmodule

// File: tb/tb_sort_result_capture.sv
// Bench for sort_result_capture: table of stream patterns with a
// scoreboard of expected results, plus abort/reset sequences.
module tb_sort_result_capture;

  localparam int SIZE = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_row = '0;
  logic [7:0] in_data = '0;
  logic       sort_done = 1'b0;
  logic [3:0] rd_index = '0;
  logic [7:0] rd_data;
  logic       busy;
  logic       capture_done;
  logic       order_error;
  logic       missing_error;
  logic       range_error;
  logic [15:0] cycles;

  sort_result_capture dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_row(in_row), .in_data(in_data),
    .sort_done(sort_done), .rd_index(rd_index), .rd_data(rd_data),
    .busy(busy), .capture_done(capture_done),
    .order_error(order_error), .missing_error(missing_error),
    .range_error(range_error), .cycles(cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    bit order;
    bit miss;
    bit rng;
    int cyc;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  vec_t sb_q[$];
  vec_t vecs[7];
  logic [7:0] mdl [16];
  bit   mseen [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int row, input int data);
    in_valid = 1'b1;
    in_row   = row[3:0];
    in_data  = data[7:0];
    if (row < SIZE) begin
      mdl[row]   = data[7:0];
      mseen[row] = 1'b1;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic zero_state(input string name);
    chk(name, int'({busy, capture_done, order_error,
                    missing_error, range_error}), 0);
    chk({name, "_cyc"}, int'(cycles), 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 16; i++) mseen[i] = 1'b0;
    zero_state("clr");
  endtask

  task automatic drive(input int mode);
    case (mode)
      0: for (int i = 0; i < SIZE; i++) wr(i, i + 1);
      1: for (int i = 0; i < SIZE; i++) wr(i, (i == 5) ? 200 : i + 1);
      2: begin
        for (int i = 0; i < 14; i++) wr(i, 10 + i);
        sort_done = 1'b1;
        step();
        sort_done = 1'b0;
      end
      3: begin
        for (int i = 0; i < 7; i++) wr(i, i + 1);
        wr(15, 8'h55);
        for (int i = 7; i < SIZE; i++) wr(i, i + 1);
      end
      4: begin
        for (int i = 0; i < 5; i++) wr(i, i / 2);
        wr(2, 1);
        for (int i = 5; i < SIZE; i++) wr(i, i / 2);
      end
      5: for (int i = SIZE - 1; i >= 0; i--) wr(i, i + 1);
      default: begin
        sort_done = 1'b1;
        step();
        sort_done = 1'b0;
      end
    endcase
  endtask

  task automatic wait_done();
    int lat;
    vec_t e;
    lat = 0;
    while (!capture_done && lat < 100) begin
      step();
      lat++;
    end
    chk("latency", lat, SIZE - 1);
    chk("busy_done", int'(busy), 0);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk($sformatf("order_m%0d", e.mode), int'(order_error), int'(e.order));
      chk($sformatf("miss_m%0d", e.mode), int'(missing_error), int'(e.miss));
      chk($sformatf("range_m%0d", e.mode), int'(range_error), int'(e.rng));
      chk($sformatf("cycles_m%0d", e.mode), int'(cycles), e.cyc);
    end
  endtask

  task automatic readout();
    for (int i = 0; i < 16; i++) begin
      if (i < SIZE && !mseen[i]) continue;
      rd_index = 4'(i);
      step();
      chk($sformatf("rd%0d", i), int'(rd_data), (i < SIZE) ? int'(mdl[i]) : 0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    sb_q.push_back(v);
    drive(v.mode);
    wait_done();
    readout();
    step();
    chk("hold_done", int'(capture_done), 1);
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 1'b0, 1'b0, 29};
    vecs[1] = '{1, 1'b1, 1'b0, 1'b0, 29};
    vecs[2] = '{2, 1'b0, 1'b1, 1'b0, 29};
    vecs[3] = '{3, 1'b0, 1'b0, 1'b1, 30};
    vecs[4] = '{4, 1'b0, 1'b0, 1'b0, 30};
    vecs[5] = '{5, 1'b0, 1'b0, 1'b0, 29};
    vecs[6] = '{6, 1'b0, 1'b1, 1'b0, 0};
    for (int i = 0; i < 16; i++) begin
      mdl[i]   = '0;
      mseen[i] = 1'b0;
    end

    step();
    step();
    rst = 1'b0;
    zero_state("reset");
    chk("reset_rd", int'(rd_data), 0);

    foreach (vecs[k]) begin
      do_clear();
      run_vec(vecs[k]);
    end

    // abort in the middle of CHECK, then a clean stream
    do_clear();
    for (int i = 0; i < SIZE; i++) wr(i, i + 1);
    for (int i = 0; i < 5; i++) step();
    chk("busy_check", int'(busy), 1);
    do_clear();
    for (int i = 0; i < 3; i++) step();
    zero_state("idle_hold");
    run_vec(vecs[0]);

    // rst while DONE forces rd_data too
    rd_index = 4'd7;
    step();
    chk("rd7", int'(rd_data), 8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_done", int'(capture_done), 0);
    chk("rst_rd", int'(rd_data), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sort_result_capture.md
Name: sort_result_capture

Overview:
- Receiving end of the bubble-sorter output stream: captures the sorted (row, data) pairs the sorter emits, stores them in a SIZE-entry buffer, checks completeness and non-decreasing order, and measures capture latency in cycles.
- Sits downstream of the sorter, in hardware builds and in throughput benches, replacing testbench-side hierarchical peeking at the sorter's done flag.

Parameters:
- SIZE, 15, number of elements in the sorted array (2..2**RW).
- DW, 8, element data width.
- RW, 4, row index width.
- CW, 16, width of the cycle counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  single-cycle pulse; re-arms the block for a new sort (same effect as rst, except rd_data is not forced).
- in_valid  in  1  in_row/in_data valid this cycle.
- in_row  in  RW  row index of the incoming element.
- in_data  in  DW  element value.
- sort_done  in  1  sorter finished flag (level); forces end of capture.
- rd_index  in  RW  readout address.
- rd_data  out  DW  buffer[rd_index], registered (1-cycle latency).
- busy  out  1  capture or check in progress.
- capture_done  out  1  result valid; held until clear/rst.
- order_error  out  1  some buffer[i-1] > buffer[i].
- missing_error  out  1  at least one row never written.
- range_error  out  1  an in_row >= SIZE was received (sticky).
- cycles  out  CW  cycles from first accepted in_valid to entry into DONE.

Behaviour:
- Reset (rst or clear): state IDLE; seen mask = 0; busy, capture_done, all error flags and cycles = 0; rd_data = 0 on rst only. Buffer contents need not be cleared.
- States: IDLE -> CAPTURE -> CHECK -> DONE.
- IDLE:
  - First in_valid: write it, go to CAPTURE, set busy, set cycles = 1.
  - sort_done with no data: go to CHECK directly.
- CAPTURE:
  - Each in_valid with in_row < SIZE writes buffer[in_row] = in_data and sets seen[in_row].
  - A rewrite of the same row overwrites silently.
  - in_row >= SIZE: no write; range_error set.
  - cycles increments every cycle, saturating at 2**CW-1.
  - Go to CHECK when all SIZE seen bits are set (including the element written this cycle) or sort_done = 1.
  - If sort_done and in_valid arrive together, the element is written first.
- CHECK:
  - Index i runs 1..SIZE-1, one comparison per cycle, so CHECK lasts SIZE-1 cycles.
  - order_error sets if buffer[i-1] > buffer[i] with both rows seen.
  - Equal values are legal.
  - missing_error = ~&seen, evaluated on entry.
  - in_valid is ignored in CHECK and DONE.
  - cycles keeps counting through CHECK; it freezes on entry to DONE.
- DONE:
  - capture_done = 1, busy = 0; flags and cycles hold.
  - Leaves only via clear/rst.
- Readout: rd_data updates every cycle from buffer[rd_index]. rd_index >= SIZE returns 0.
- clear/rst mid-CAPTURE or mid-CHECK: aborts immediately and returns to IDLE with no partial flags.
- Latency: the last element accepted in cycle N gives CHECK from N+1, and capture_done at N+SIZE.

Test Plan:
- Write rows 0..14 with data 1,2,...,15 on consecutive cycles: capture_done = 1 at cycle 29 after the first write; no errors; cycles = 29; rd_index = 7 gives rd_data = 8.
- Same stream but row 5 = 200: capture_done = 1; order_error = 1; missing_error = 0.
- Write rows 0..13 only (values 10..23), then pulse sort_done: missing_error = 1; order_error = 0.
- Send in_row = 15 with data 0x55 mid-stream: range_error = 1; no buffer change.
- Duplicate rows written in non-decreasing order: no order_error.
- Assert clear during CHECK: all outputs return to 0 next cycle; a fresh stream of 0..14 completes normally.
- rst while in DONE: capture_done = 0 and rd_data = 0 after one clock.
